// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain: one register per set STAGE_MASK bit, wires elsewhere.
// Supports backpressure, bubble collapsing and a synchronous flush.
module pipe_stage_chain #(
    parameter int          DWIDTH     = 32,
    parameter int          NUM_SLOTS  = 5,
    parameter logic [31:0] STAGE_MASK = 32'b11010,
    parameter int          OCC_W      = $clog2(NUM_SLOTS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o,
    output logic [OCC_W-1:0]  occupancy_o,
    output logic [OCC_W-1:0]  depth_o
);

    function automatic int count_ones(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 0; i < NUM_SLOTS && i < 32; i++) begin
            n += int'(m[i]);
        end
        return n;
    endfunction

    localparam int DEPTH = count_ones(STAGE_MASK);

    generate
        if ((STAGE_MASK >> NUM_SLOTS) != 0) begin : g_bad_mask
            $error("pipe_stage_chain: STAGE_MASK has bits at or above NUM_SLOTS");
        end
    endgenerate

    logic [NUM_SLOTS-1:0] v_vec;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gen_slot
            logic              vin;
            logic [DWIDTH-1:0] din;
            logic              vout;
            logic [DWIDTH-1:0] dout;
            logic              rdy;
            logic              rdy_down;

            if (gi == 0) begin : g_src
                assign vin = in_valid_i;
                assign din = in_data_i;
            end else begin : g_src
                assign vin = gen_slot[gi-1].vout;
                assign din = gen_slot[gi-1].dout;
            end

            if (gi == NUM_SLOTS - 1) begin : g_sink
                assign rdy_down = out_ready_i;
            end else begin : g_sink
                assign rdy_down = gen_slot[gi+1].rdy;
            end

            if (STAGE_MASK[gi]) begin : g_reg
                logic              v_reg;
                logic [DWIDTH-1:0] d_reg;

                // An empty register is always ready, which lets bubbles collapse.
                assign rdy = !v_reg || rdy_down;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        v_reg <= 1'b0;
                        d_reg <= '0;
                    end else if (flush_i) begin
                        v_reg <= 1'b0;
                    end else if (vin && rdy) begin
                        v_reg <= 1'b1;
                        d_reg <= din;
                    end else if (rdy) begin
                        v_reg <= 1'b0;
                    end
                end

                assign vout       = v_reg;
                assign dout       = d_reg;
                assign v_vec[gi]  = v_reg;
            end else begin : g_wire
                assign rdy        = rdy_down;
                assign vout       = vin;
                assign dout       = din;
                assign v_vec[gi]  = 1'b0;
            end
        end
    endgenerate

    // Gating with reset_n keeps the outputs quiet even when the chain is a pure wire.
    assign in_ready_o  = gen_slot[0].rdy & ~flush_i & reset_n;
    assign out_valid_o = gen_slot[NUM_SLOTS-1].vout & ~flush_i & reset_n;
    assign out_data_o  = reset_n ? gen_slot[NUM_SLOTS-1].dout : '0;

    always_comb begin
        occupancy_o = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occupancy_o = occupancy_o + OCC_W'(v_vec[i]);
        end
    end

    assign depth_o = OCC_W'(DEPTH);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: mask 11010 chain plus a mask-0 passthrough instance.
module tb_pipe_stage_chain;

    localparam int DW    = 32;
    localparam int OCC_W = 3;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] depth;

    logic             p_flush;
    logic             p_in_valid;
    logic             p_in_ready;
    logic [DW-1:0]    p_in_data;
    logic             p_out_valid;
    logic             p_out_ready;
    logic [DW-1:0]    p_out_data;
    logic [OCC_W-1:0] p_occupancy;
    logic [OCC_W-1:0] p_depth;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_chain #(.DWIDTH(DW), .NUM_SLOTS(5), .STAGE_MASK(32'b11010)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occupancy_o(occupancy), .depth_o(depth)
    );

    pipe_stage_chain #(.DWIDTH(DW), .NUM_SLOTS(5), .STAGE_MASK(32'b0)) dut_pass (
        .clk(clk), .reset_n(reset_n), .flush_i(p_flush),
        .in_valid_i(p_in_valid), .in_ready_o(p_in_ready), .in_data_i(p_in_data),
        .out_valid_o(p_out_valid), .out_ready_i(p_out_ready), .out_data_o(p_out_data),
        .occupancy_o(p_occupancy), .depth_o(p_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        logic exp_rdy;
        logic exp_v;
        int acc;
        int outs;

        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        p_flush     = 1'b0;
        p_in_valid  = 1'b0;
        p_in_data   = '0;
        p_out_ready = 1'b0;

        // 1: reset and idle
        #1;
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_data", out_data, 32'd0);
        check_value("rst_occupancy", 32'(occupancy), 32'd0);
        check_value("rst_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        #1;
        check_value("idle_in_ready", 32'(in_ready), 32'd1);
        check_value("idle_occupancy", 32'(occupancy), 32'd0);
        check_value("idle_out_valid", 32'(out_valid), 32'd0);
        check_value("depth", 32'(depth), 32'd3);
        next_cycle();

        // 2: back-to-back stream 0x1..0x8, no backpressure
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            in_valid = (j < 8);
            in_data  = 32'(j + 1);
            #1;
            if (j < 8) check_value($sformatf("stream_in_ready[%0d]", j), 32'(in_ready), 32'd1);
            exp_v = (j >= 3 && j <= 10);
            check_value($sformatf("stream_out_valid[%0d]", j), 32'(out_valid), 32'(exp_v));
            if (exp_v) check_value($sformatf("stream_out_data[%0d]", j), out_data, 32'(j - 2));
            acc  = (j < 8) ? j : 8;
            outs = (j > 3) ? ((j - 3 < 8) ? j - 3 : 8) : 0;
            check_value($sformatf("stream_occ[%0d]", j), 32'(occupancy), 32'(acc - outs));
            next_cycle();
        end
        in_valid = 1'b0;

        // 3: backpressure while offering 0xA..0xF
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'hA + idx);
            #1;
            exp_rdy = (c < 3);
            check_value($sformatf("bp_in_ready[%0d]", c), 32'(in_ready), 32'(exp_rdy));
            check_value($sformatf("bp_occ[%0d]", c), 32'(occupancy), 32'((c < 3) ? c : 3));
            check_value($sformatf("bp_out_valid[%0d]", c), 32'(out_valid), 32'(c >= 3));
            check_value($sformatf("bp_out_data[%0d]", c), out_data, (c >= 3) ? 32'hA : 32'h8);
            next_cycle();
            if (exp_rdy) idx++;
        end
        for (int r = 0; r < 7; r++) begin
            out_ready = 1'b1;
            in_valid  = (idx < 6);
            in_data   = 32'(32'hA + idx);
            #1;
            if (in_valid) check_value($sformatf("rel_in_ready[%0d]", r), 32'(in_ready), 32'd1);
            check_value($sformatf("rel_out_valid[%0d]", r), 32'(out_valid), 32'(r < 6));
            if (r < 6) check_value($sformatf("rel_out_data[%0d]", r), out_data, 32'(32'hA + r));
            check_value($sformatf("rel_occ[%0d]", r), 32'(occupancy), 32'((6 - r < 3) ? 6 - r : 3));
            next_cycle();
            if (in_valid) idx++;
        end
        in_valid = 1'b0;

        // 4: bubble collapse behind a stalled head entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h20;
        #1;
        check_value("bub_in_ready0", 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        in_valid = 1'b1;
        in_data  = 32'h21;
        #1;
        check_value("bub_occ1", 32'(occupancy), 32'd1);
        check_value("bub_out_valid", 32'(out_valid), 32'd1);
        check_value("bub_out_data", out_data, 32'h20);
        check_value("bub_in_ready1", 32'(in_ready), 32'd1);
        next_cycle();
        in_data = 32'h22;
        #1;
        check_value("bub_in_ready2", 32'(in_ready), 32'd1);
        check_value("bub_occ2", 32'(occupancy), 32'd2);
        next_cycle();
        in_data = 32'h23;
        #1;
        check_value("bub_in_ready_full", 32'(in_ready), 32'd0);
        check_value("bub_occ_full", 32'(occupancy), 32'd3);
        check_value("bub_data_held", out_data, 32'h20);
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            #1;
            check_value($sformatf("bub_drain_valid[%0d]", d), 32'(out_valid), 32'd1);
            check_value($sformatf("bub_drain_data[%0d]", d), out_data, 32'(32'h20 + d));
            next_cycle();
        end
        #1;
        check_value("bub_drained_occ", 32'(occupancy), 32'd0);

        // 5: flush with two entries in flight and a pending input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h30;
        next_cycle();
        in_data = 32'h31;
        next_cycle();
        in_data = 32'h32;
        #1;
        check_value("fl_occ_before", 32'(occupancy), 32'd2);
        check_value("fl_in_ready_noflush", 32'(in_ready), 32'd1);
        flush = 1'b1;
        #1;
        check_value("fl_in_ready", 32'(in_ready), 32'd0);
        check_value("fl_out_valid", 32'(out_valid), 32'd0);
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_value("fl_occ_after", 32'(occupancy), 32'd0);
        check_value("fl_out_valid_after", 32'(out_valid), 32'd0);
        next_cycle();

        // 6a: mask 0 passthrough
        p_in_valid  = 1'b1;
        p_in_data   = 32'h55;
        p_out_ready = 1'b1;
        #1;
        check_value("pt_out_valid", 32'(p_out_valid), 32'd1);
        check_value("pt_out_data", p_out_data, 32'h55);
        check_value("pt_in_ready", 32'(p_in_ready), 32'd1);
        check_value("pt_occ", 32'(p_occupancy), 32'd0);
        check_value("pt_depth", 32'(p_depth), 32'd0);
        p_out_ready = 1'b0;
        p_in_data   = 32'h66;
        #1;
        check_value("pt_in_ready_stall", 32'(p_in_ready), 32'd0);
        check_value("pt_out_data2", p_out_data, 32'h66);
        p_out_ready = 1'b1;
        p_flush     = 1'b1;
        #1;
        check_value("pt_flush_in_ready", 32'(p_in_ready), 32'd0);
        check_value("pt_flush_out_valid", 32'(p_out_valid), 32'd0);
        p_flush    = 1'b0;
        p_in_valid = 1'b0;
        next_cycle();

        // 6b: asynchronous reset in the middle of a stream
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h40 + c);
            if (c < 3) next_cycle();
        end
        #1;
        check_value("ar_pre_valid", 32'(out_valid), 32'd1);
        check_value("ar_pre_data", out_data, 32'h40);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("ar_out_valid", 32'(out_valid), 32'd0);
        check_value("ar_occ", 32'(occupancy), 32'd0);
        check_value("ar_in_ready", 32'(in_ready), 32'd0);
        check_value("ar_out_data", out_data, 32'd0);
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            in_data  = 32'h50;
            #1;
            check_value($sformatf("ar_post_valid[%0d]", c), 32'(out_valid), 32'(c == 3));
            if (c == 3) check_value("ar_post_data", out_data, 32'h50);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
